load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the byte-wide data memory port; the counterpart of the memory responder.
//  Accepts one load/store request from the execute stage.
//  Serialises it into 1, 2 or 4 little-endian byte transfers on the memory port.
//  For loads, reassembles the returned bytes and zero- or sign-extends them to 32 bits.
//  Sits between the core's EX/MEM stage and data memory; one request in flight at a time.
// PARAMETERS
//  ADDR_W   32   width of request address and memory address
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present from core
//  req_ready  out  1       unit idle, request accepted when req_valid && req_ready
//  req_we     in   1       1 = store, 0 = load
//  req_op     in   3       [2] word, [1] half, [0] signed (loads only); 000 LBU 001 LB 010 LHU 011 LH 1xx LW/SW
//  req_addr   in   ADDR_W  byte address of first (least-significant) byte
//  req_wdata  in   32      store data; bytes used = 1/2/4 by req_op
//  resp_valid out  1       one-cycle pulse: request complete
//  resp_rdata out  32      load result, valid with resp_valid; 0 for stores
//  mem_en     out  1       memory access strobe this cycle
//  mem_we     out  1       1 = byte write, 0 = byte read (meaningful only with mem_en)
//  mem_addr   out  ADDR_W  byte address of current transfer
//  mem_wdata  out  8       write byte
//  mem_rdata  in   8       read byte, valid the cycle after a read strobe (1-cycle latency)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  Reset asserted mid-operation:
//    - aborts immediately; the partial store is not rolled back;
//    - no resp_valid is produced for the aborted request.
//  Byte count N: req_op[2] ? 4 : req_op[1] ? 2 : 1. Request fields are latched on acceptance.
//  States:
//    - IDLE -> XFER on accept.
//    - XFER issues byte k=0..N-1, one per cycle:
//      - mem_addr = addr+k, with ADDR_W-bit modular wrap (all-ones + 1 = 0);
//      - mem_wdata = wdata[8k+7:8k] for stores.
//    - After k=N-1: a store goes XFER -> DONE; a load goes XFER -> LAST, where the final byte is captured.
//    - LAST -> DONE.
//    - DONE: resp_valid=1 for one cycle, then -> IDLE.
//  Timing (accept edge = cycle 0):
//    - memory strobes in cycles 1..N;
//    - store resp_valid in cycle N+1;
//    - load resp_valid in cycle N+2.
//    - Back-to-back: req_ready=1 only in IDLE, so the next accept is no earlier than the cycle after resp_valid.
//  Load capture: byte read at cycle k+1 lands in resp_rdata[8k+7:8k] at cycle k+2.
//  Extension is applied in LAST, using the assembled byte:
//    - signed: upper bits = copy of bit 7 (byte) or bit 15 (half);
//    - unsigned: upper bits = 0;
//    - word: no extension.
//  req_op[0] is ignored for stores and for word loads.
//  resp_rdata holds its value until the next request is accepted, then clears to 0.
//  Inputs other than req_* are ignored outside IDLE. mem_rdata is sampled only in the capture cycles.
// TESTING
//  - Store: SW addr 0x10, data 0xDEADBEEF ->
//    - writes 0xEF@0x10, 0xBE@0x11, 0xAD@0x12, 0xDE@0x13 in cycles 1-4;
//    - resp_valid in cycle 5.
//  - Sign extension after that store (model memory with 1-cycle read latency):
//    - LB 0x10 -> 0xFFFFFFEF;
//    - LBU 0x10 -> 0x000000EF;
//    - LH 0x12 -> 0xFFFFDEAD;
//    - LHU 0x12 -> 0x0000DEAD;
//    - LW 0x10 -> 0xDEADBEEF, resp_valid in cycle 6.
//  - Positive sign extension: SB 0x20 = 0x7F; LB 0x20 -> 0x0000007F. SH 0x22 = 0x1234; LH -> 0x00001234.
//  - Address wrap: SW addr 0xFFFFFFFE, data 0x11223344 ->
//    - byte addresses are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1;
//    - bytes written 0x44, 0x33, 0x22, 0x11.
//  - Handshake: hold req_valid=1 with two queued requests ->
//    - req_ready=0 from cycle 1 until the cycle after resp_valid;
//    - the second request is accepted exactly once, with no memory strobes in between.
//  - Async reset: drop rst_n between clock edges during byte 2 of an SW ->
//    - all outputs return to reset values immediately, and resp_valid never pulses;
//    - after rst_n rises, the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: serialises one load/store into little-endian byte transfers and reassembles loads
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;
  state_t state, state_nx;
  logic              we;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [2:0]        k;
  logic [2:0]        n;
  logic [2:0]        kc;
  logic [31:0]       asm_data;
  logic [31:0]       ext_data;
  assign n  = op[2] ? 3'd4 : op[1] ? 3'd2 : 3'd1;
  assign kc = k - 3'd1;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next-state logic: loads need one extra cycle to capture the final byte
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid ? XFER : IDLE;
      XFER: state_nx = (k == n - 3'd1) ? (we ? DONE : LAST) : XFER;
      LAST: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs: memory port is driven only while transferring, zero otherwise
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == DONE;
    mem_en     = state == XFER;
    mem_we     = state == XFER && we;
    mem_addr   = state == XFER ? addr + ADDR_W'(k) : '0;
    mem_wdata  = (state == XFER && we) ? wdata[{k[1:0], 3'b000} +: 8] : '0;
  end
  // Byte k-1 returns while byte k is being strobed; splice it into the result
  always_comb begin
    asm_data = resp_rdata;
    asm_data[{kc[1:0], 3'b000} +: 8] = mem_rdata;
    ext_data = op[2] ? asm_data :
               op[1] ? {{16{op[0] & asm_data[15]}}, asm_data[15:0]} :
                       {{24{op[0] & asm_data[7]}}, asm_data[7:0]};
  end
  // Request latch, byte counter and load result assembly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we         <= 1'b0;
      op         <= '0;
      addr       <= '0;
      wdata      <= '0;
      k          <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we         <= req_we;
          op         <= req_op;
          addr       <= req_addr;
          wdata      <= req_wdata;
          k          <= '0;
          resp_rdata <= '0;
        end
        XFER: begin
          k <= k + 3'd1;
          if (!we && k != 3'd0) resp_rdata <= asm_data;
        end
        LAST: resp_rdata <= ext_data;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks against a byte-array memory reference
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        mem_init = 1'b1;
  logic        h_we = 1'b0;
  logic [2:0]  h_op = '0;
  logic [31:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte memory with 1-cycle read latency; garbage on the read bus when not reading
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] o);
    return o[2] ? 4 : o[1] ? 2 : 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
    int unsigned nb = nbytes(o);
    longint v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[8'(a + 32'(i))]) << (8 * i);
    if (nb < 4 && o[0] && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  task automatic chk_reset_outs(input string t);
    chk({t, "_ready"}, 32'(req_ready), 1);
    chk({t, "_resp_valid"}, 32'(resp_valid), 0);
    chk({t, "_resp_rdata"}, resp_rdata, 0);
    chk({t, "_mem_en"}, 32'(mem_en), 0);
    chk({t, "_mem_we"}, 32'(mem_we), 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after resp_valid
  task automatic do_req(input logic w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, input logic hold, output logic [31:0] got);
    int unsigned nb = nbytes(o);
    int unsigned last = w ? nb + 1 : nb + 2;
    logic [31:0] exp = w ? 32'h0 : ref_load(o, a);
    chk("ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = w; req_op = o; req_addr = a; req_wdata = d;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk("ready_busy", 32'(req_ready), 0);
      chk("resp_valid", 32'(resp_valid), 32'(c == last));
      chk("mem_en", 32'(mem_en), 32'(c <= nb));
      if (c <= nb) begin
        chk("mem_we", 32'(mem_we), 32'(w));
        chk("mem_addr", mem_addr, a + 32'(c - 1));
        if (w) chk("mem_wdata", 32'(mem_wdata), 32'(8'(d >> (8 * (c - 1)))));
      end
      if (c == 1) chk("rdata_clr", resp_rdata, 0);
      if (c == last) begin
        chk("resp_rdata", resp_rdata, exp);
        got = resp_rdata;
      end
      req_valid = hold;
      if (hold) begin req_we = h_we; req_op = h_op; req_addr = h_addr; req_wdata = h_wdata; end
    end
    if (w) for (int i = 0; i < nb; i++) ref_mem[8'(a + 32'(i))] = d[8 * i +: 8];
    @(negedge clk);
    chk("rdata_hold", resp_rdata, exp);
    chk("idle_mem_en", 32'(mem_en), 0);
  endtask

  logic [31:0] got;
  logic        r_we [41];
  logic [2:0]  r_op [41];
  logic [31:0] r_addr [41];
  logic [31:0] r_wdata [41];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1, 3'b100, 32'h10, 32'hDEADBEEF, 0, got);
    do_req(0, 3'b001, 32'h10, 0, 0, got); chk("LB_spec", got, 32'hFFFFFFEF);
    do_req(0, 3'b000, 32'h10, 0, 0, got); chk("LBU_spec", got, 32'h000000EF);
    do_req(0, 3'b011, 32'h12, 0, 0, got); chk("LH_spec", got, 32'hFFFFDEAD);
    do_req(0, 3'b010, 32'h12, 0, 0, got); chk("LHU_spec", got, 32'h0000DEAD);
    do_req(0, 3'b100, 32'h10, 0, 0, got); chk("LW_spec", got, 32'hDEADBEEF);
    do_req(1, 3'b000, 32'h20, 32'h0000007F, 0, got);
    do_req(0, 3'b001, 32'h20, 0, 0, got); chk("LB_pos", got, 32'h0000007F);
    do_req(1, 3'b010, 32'h22, 32'h00001234, 0, got);
    do_req(0, 3'b011, 32'h22, 0, 0, got); chk("LH_pos", got, 32'h00001234);
    do_req(1, 3'b100, 32'hFFFFFFFE, 32'h11223344, 0, got);
    do_req(0, 3'b100, 32'hFFFFFFFE, 0, 0, got); chk("LW_wrap", got, 32'h11223344);
    h_we = 1'b0; h_op = 3'b100; h_addr = 32'h30; h_wdata = 32'h0;
    do_req(1, 3'b100, 32'h30, 32'hCAFEF00D, 1, got);
    do_req(0, 3'b100, 32'h30, 0, 0, got); chk("LW_b2b", got, 32'hCAFEF00D);
    // Reset during the second byte of a word store: only byte 0 reaches memory
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b100; req_addr = 32'h40; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_strobe", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 0);
    end
    rst_n = 1'b1;
    ref_mem[8'h40] = 8'hD4;
    @(negedge clk);
    do_req(0, 3'b100, 32'h40, 0, 0, got);
    for (int i = 0; i <= 40; i++) begin
      r_we[i] = 1'($urandom);
      r_op[i] = 3'($urandom);
      r_addr[i] = ($urandom % 8 == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      r_wdata[i] = $urandom;
    end
    for (int i = 0; i < 40; i++) begin
      h_we = r_we[i + 1]; h_op = r_op[i + 1]; h_addr = r_addr[i + 1]; h_wdata = r_wdata[i + 1];
      do_req(r_we[i], r_op[i], r_addr[i], r_wdata[i], 1'($urandom), got);
    end
    req_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
